cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter_pkg.sv | 38 +++
 rtl/cache_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg
// Types and constants shared by the ICACHE/DCACHE memory arbiter and its bench.
//   - arb_state_e : arbiter FSM states
//   - req_id_e    : requester identifiers (REQ_I = 0, REQ_D = 1)
//   - ARB_ADDR_W / ARB_LINE_W : default line-address and line-data widths
//   - rr_pick     : round-robin winner selection helper
package cache_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 28;
  localparam int ARB_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // On a tie the requester that was not served last wins; a lone
  // requester always wins.
  function automatic req_id_e rr_pick(logic pend_i, logic pend_d, req_id_e last_served);
    req_id_e win;
    if (pend_i && pend_d) begin
      win = (last_served == REQ_D) ? REQ_I : REQ_D;
    end else if (pend_d) begin
      win = REQ_D;
    end else begin
      win = REQ_I;
    end
    return win;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Arbitrates ICACHE and DCACHE line misses/writebacks onto one memory port.
// One transaction at a time: IDLE -> GRANT_I/GRANT_D -> DONE -> IDLE.
//
// Ports
//   clk, rst                     : clock, asynchronous active-high reset
//   i_read, i_write, i_addr,
//   i_wdata -> i_rdata, i_ready  : ICACHE request / response
//   d_read, d_write, d_addr,
//   d_wdata -> d_rdata, d_ready  : DCACHE request / response
//   mem_read, mem_write,
//   mem_addr, mem_wdata          : memory command (valid only in GRANT_x)
//   mem_rdata, mem_ready         : memory response (ready is a one-cycle pulse)
//
// Build option
//   ARB_ROUND_ROBIN_EN : when defined, ties alternate between I and D;
//                        otherwise D always has priority over I.
//
// State table
//   IDLE    | waiting for a request; latches winner's command on exit
//   GRANT_I | ICACHE command driven on mem_*, waiting for mem_ready
//   GRANT_D | DCACHE command driven on mem_*, waiting for mem_ready
//   DONE    | one-cycle x_ready pulse to the granted requester
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        state_q, state_d;
  req_id_e           winner;
  req_id_e           gnt_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic              pend_i, pend_d, take;

  assign pend_i = i_read | i_write;
  assign pend_d = d_read | d_write;
  assign take   = (state_q == IDLE) && (pend_i || pend_d);

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e last_q;

  // Reset value REQ_I makes D the first tie winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_I;
    end else if (take) begin
      last_q <= winner;
    end
  end

  assign winner = rr_pick(pend_i, pend_d, last_q);
`else
  assign winner = pend_d ? REQ_D : REQ_I;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requester inputs are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pend_i || pend_d) begin
          state_d = (winner == REQ_D) ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ready) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture on IDLE exit. A read+write request issues the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= REQ_I;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      gnt_q   <= winner;
      wr_q    <= (winner == REQ_D) ? d_write : i_write;
      addr_q  <= (winner == REQ_D) ? d_addr  : i_addr;
      wdata_q <= (winner == REQ_D) ? d_wdata : i_wdata;
    end
  end

  // Returned lines update only on read completion so writebacks leave the
  // requester's last line intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if ((state_q == GRANT_I) && mem_ready && !wr_q) begin
      i_rdata_q <= mem_rdata;
    end else if ((state_q == GRANT_D) && mem_ready && !wr_q) begin
      d_rdata_q <= mem_rdata;
    end
  end

  // Output decode
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    case (state_q)
      GRANT_I, GRANT_D: begin
        mem_read  = !wr_q;
        mem_write = wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      DONE: begin
        i_ready = (gnt_q == REQ_I);
        d_ready = (gnt_q == REQ_D);
      end
      default: ;
    endcase
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_cmd_t;

  typedef struct {
    bit            is_d;
    logic [LW-1:0] rdata;
  } rsp_t;

  mem_cmd_t      mem_exp_q[$];
  rsp_t          rsp_exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            rr_last_d = 1'b0;   // model: last served requester was D
  logic [LW-1:0] model_rdata[2];     // model: last line returned to I / D
  int            fixed_lat = -1;
  bit            hold_mem = 1'b0;
  bit            i_done, d_done;
  int            cmd_start_cyc, ready_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory content model: each line address maps to a fixed line value.
  function automatic logic [LW-1:0] mem_line(logic [AW-1:0] a);
    logic [31:0] x;
    x = {4'h0, a};
    return {x ^ 32'hA5A5_A5A5, x * 32'd3, ~x, x + 32'h0000_1000};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    rr_last_d      = 1'b0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
  endtask

  // Memory responder: random garbage on mem_rdata except on the ready pulse.
  initial begin : responder
    bit busy;
    int cnt;
    busy      = 1'b0;
    cnt       = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = rand_line();
      if (rst || hold_mem || !(mem_read || mem_write)) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        end
        if (cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_line(mem_addr);
          busy      = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: pops expected memory commands and responses as the DUT shows them.
  initial begin : monitor
    bit       prev_act;
    mem_cmd_t cur;
    rsp_t     r;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_act = 1'b0;
      end else begin
        check("mem_rw_exclusive", mem_read & mem_write, '0);
        if (mem_read || mem_write) begin
          if (!prev_act) begin
            cmd_start_cyc = cyc;
            if (mem_exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL mem_cmd_unexpected: got addr %h, expected no command", mem_addr);
              cur.wr    = mem_write;
              cur.addr  = mem_addr;
              cur.wdata = mem_wdata;
            end else begin
              cur = mem_exp_q.pop_front();
            end
          end
          check("mem_write", mem_write, cur.wr);
          check("mem_read", mem_read, !cur.wr);
          check("mem_addr", mem_addr, cur.addr);
          if (cur.wr) check("mem_wdata", mem_wdata, cur.wdata);
          prev_act = 1'b1;
        end else begin
          prev_act = 1'b0;
        end

        check("ready_exclusive", i_ready & d_ready, '0);
        if (i_ready || d_ready) begin
          ready_cyc = cyc;
          if (rsp_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ready_unexpected: i_ready=%0b d_ready=%0b, expected no pulse", i_ready, d_ready);
          end else begin
            r = rsp_exp_q.pop_front();
            check("ready_id", d_ready, r.is_d);
            if (r.is_d) check("d_rdata", d_rdata, r.rdata);
            else        check("i_rdata", i_rdata, r.rdata);
          end
          if (i_ready) i_done = 1'b1;
          if (d_ready) d_done = 1'b1;
        end
      end
    end
  end

  // One round: requests presented together from IDLE; index 0 = I, 1 = D.
  task automatic run_txn(input bit use_i, input bit use_d,
                         input bit rd_i, input bit wr_i, input logic [AW-1:0] a_i, input logic [LW-1:0] w_i,
                         input bit rd_d, input bit wr_d, input logic [AW-1:0] a_d, input logic [LW-1:0] w_d,
                         input bit scramble, output int req_cyc);
    bit            wr[2];
    logic [AW-1:0] a[2];
    int            order[$];
    int            t;
    bit            first_d;
    wr[0] = wr_i; wr[1] = wr_d;
    a[0]  = a_i;  a[1]  = a_d;

    if (use_i && use_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      first_d = !rr_last_d;
`else
      first_d = 1'b1;
`endif
      if (first_d) order = {1, 0};
      else         order = {0, 1};
    end else if (use_d) begin
      order = {1};
    end else begin
      order = {0};
    end

    foreach (order[n]) begin
      int       id;
      mem_cmd_t c;
      rsp_t     r;
      id      = order[n];
      c.wr    = wr[id];
      c.addr  = a[id];
      c.wdata = (id == 1) ? w_d : w_i;
      mem_exp_q.push_back(c);
      if (!wr[id]) model_rdata[id] = mem_line(a[id]);
      r.is_d  = (id == 1);
      r.rdata = model_rdata[id];
      rsp_exp_q.push_back(r);
      rr_last_d = (id == 1);
    end

    i_done  = 1'b0;
    d_done  = 1'b0;
    req_cyc = cyc;
    i_read  = use_i & rd_i; i_write = use_i & wr_i; i_addr = a_i; i_wdata = w_i;
    d_read  = use_d & rd_d; d_write = use_d & wr_d; d_addr = a_d; d_wdata = w_d;

    t = 0;
    while (((use_i && !i_done) || (use_d && !d_done)) && t < 80) begin
      @(posedge clk); #1;
      t++;
      if (i_done) begin i_read = 1'b0; i_write = 1'b0; end
      if (d_done) begin d_read = 1'b0; d_write = 1'b0; end
      // The first winner is already captured; wiggling its inputs must not
      // reach the memory port.
      if (scramble) begin
        if (order[0] == 0 && !i_done) begin
          i_addr = AW'($urandom()); i_wdata = rand_line();
        end else if (order[0] == 1 && !d_done) begin
          d_addr = AW'($urandom()); d_wdata = rand_line();
        end
      end
    end
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;

    if (t >= 80) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got no ready within 80 cycles, expected i_done=%0b d_done=%0b", use_i, use_d);
      rst = 1'b1;
      @(posedge clk); #1;
      mem_exp_q.delete();
      rsp_exp_q.delete();
      model_reset();
      rst = 1'b0;
    end else begin
      check("i_rdata_hold", i_rdata, model_rdata[0]);
      check("d_rdata_hold", d_rdata, model_rdata[1]);
    end
  endtask

  task automatic rand_txn(input bit use_i, input bit use_d, input bit scramble);
    int m0, m1, rc;
    m0 = int'($urandom_range(0, 2));
    m1 = int'($urandom_range(0, 2));
    run_txn(use_i, use_d,
            m0 != 1, m0 != 0, AW'($urandom()), rand_line(),
            m1 != 1, m1 != 0, AW'($urandom()), rand_line(),
            scramble, rc);
  endtask

  task automatic reset_mid_grant();
    mem_cmd_t c;
    int       rc;
    hold_mem = 1'b1;
    c.wr     = 1'b0;
    c.addr   = 28'h0ABCDE0;
    c.wdata  = '0;
    mem_exp_q.push_back(c);
    d_read = 1'b1; d_write = 1'b0; d_addr = 28'h0ABCDE0; d_wdata = rand_line();
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_mem_read", mem_read, 1);
    rst = 1'b1;
    #1;
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    d_read = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst      = 1'b0;
    hold_mem = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("no_ready_after_reset", rsp_exp_q.size(), 0);
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 28'h0000FF0, rand_line(), 1'b0, rc);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int rc;
    int sel;
    rst = 1'b1;
    i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    model_reset();
    #1;
    check("reset_mem_read", mem_read, 0);
    check("reset_mem_write", mem_write, 0);
    check("reset_i_ready", i_ready, 0);
    check("reset_d_ready", d_ready, 0);
    check("reset_i_rdata", i_rdata, 0);
    check("reset_d_rdata", d_rdata, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Lone i_read, mem_ready in the fourth grant cycle.
    fixed_lat = 3;
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 28'h0000010, rand_line(), 1'b0, 1'b0, '0, '0, 1'b0, rc);
    check("lat_cmd_start", cmd_start_cyc - rc, 1);
    check("lat_ready", ready_cyc - rc, 5);

    // Minimum latency: mem_ready in the first grant cycle.
    fixed_lat = 0;
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 28'h0000020, rand_line(), 1'b0, rc);
    check("lat_min_ready", ready_cyc - rc, 2);

    // Simultaneous d_write and i_read.
    fixed_lat = 1;
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, 28'h0000030, rand_line(),
            1'b0, 1'b1, 28'h0000040, rand_line(), 1'b1, rc);

    // Four simultaneous rounds: tie-break order.
    fixed_lat = -1;
    repeat (4) rand_txn(1'b1, 1'b1, 1'b0);

    // d_read and d_write together issue a write only.
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 28'h0000050, rand_line(), 1'b0, rc);

    // Reset while D is granted.
    reset_mid_grant();

    // i_addr moving while I is granted.
    fixed_lat = 3;
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 28'h0000060, rand_line(), 1'b0, 1'b0, '0, '0, 1'b1, rc);

    // Random rounds.
    fixed_lat = -1;
    repeat (40) begin
      sel = int'($urandom_range(1, 3));
      rand_txn(sel[0], sel[1], 1'($urandom_range(0, 1)));
    end

    check("mem_exp_drained", mem_exp_q.size(), 0);
    check("rsp_exp_drained", rsp_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
